// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and sizing helpers for the ROM download controller
package rom_dl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      HOLD  = 2'd2,
      READY = 2'd3
   } dl_state_t;

   localparam int POST_HOLD_DEF = 16;
   localparam int HOLD_W        = $clog2(POST_HOLD_DEF + 1);

   // Hold counter width for an arbitrary POST_HOLD value.
   function automatic int calc_hold_w(input int post_hold);
      return $clog2(post_hold + 1);
   endfunction

endpackage

// File: rtl/rom_download_ctrl.sv
// rtl/rom_download_ctrl.sv - filters the hps_io ROM download stream, drives the core ROM-load port and core reset
module rom_download_ctrl
   import rom_dl_pkg::*;
#(
   parameter logic [15:0] ROM_INDEX      = 16'd0,
   parameter int          ADDR_W         = 18,
   parameter int          EXPECTED_BYTES = 0,
   parameter int          POST_HOLD      = 16
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [15:0]       ioctl_index,
   output logic [ADDR_W-1:0] dn_addr,
   output logic [7:0]        dn_data,
   output logic              dn_wr,
   output logic              core_reset,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   byte_count,
   output logic [7:0]        checksum
);

   localparam int               CNT_W     = calc_hold_w(POST_HOLD);
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(POST_HOLD - 1);
   localparam logic [ADDR_W:0]  EXP_CNT   = (ADDR_W + 1)'(EXPECTED_BYTES);
   localparam logic [ADDR_W:0]  CNT_MAX   = '1;

   dl_state_t         r_state;
   dl_state_t         w_state_nx;
   logic              r_dl_sel_q;
   logic [CNT_W-1:0]  r_hold_cnt;
   logic [ADDR_W-1:0] r_dn_addr;
   logic [7:0]        r_dn_data;
   logic              r_dn_wr;
   logic              r_core_reset;
   logic              r_load_done;
   logic              r_load_err;
   logic [ADDR_W:0]   r_byte_count;
   logic [7:0]        r_checksum;

   logic w_dl_sel;
   logic w_dl_rise;
   logic w_in_range;
   logic w_seq_ok;
   logic w_clear;
   logic w_accept;
   logic w_hold_load;
   logic w_hold_dec;
   logic w_finish;

   assign w_dl_sel   = ioctl_download && (ioctl_index == ROM_INDEX);
   assign w_dl_rise  = w_dl_sel && !r_dl_sel_q;
   assign w_in_range = (ioctl_addr[24:ADDR_W] == '0);
   // A saturated count can never match an in-range address, so its top bit forces non-sequential.
   assign w_seq_ok   = !r_byte_count[ADDR_W] &&
                       (ioctl_addr[ADDR_W-1:0] == r_byte_count[ADDR_W-1:0]);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_clear     = 1'b0;
      w_accept    = 1'b0;
      w_hold_load = 1'b0;
      w_hold_dec  = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_dl_sel) begin
               w_state_nx = LOAD;
               w_clear    = 1'b1;
            end
         end
         LOAD: begin
            w_accept = ioctl_wr;
            if (!w_dl_sel) begin
               w_state_nx  = HOLD;
               w_hold_load = 1'b1;
            end
         end
         HOLD: begin
            if (w_dl_sel) begin
               w_state_nx = LOAD;
               w_clear    = 1'b1;
            end else if (r_hold_cnt == '0) begin
               w_state_nx = READY;
               w_finish   = 1'b1;
            end else begin
               w_hold_dec = 1'b1;
            end
         end
         READY: begin
            if (w_dl_rise) begin
               w_state_nx = LOAD;
               w_clear    = 1'b1;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_dl_sel_q   <= 1'b0;
         r_hold_cnt   <= '0;
         r_dn_addr    <= '0;
         r_dn_data    <= '0;
         r_dn_wr      <= 1'b0;
         r_core_reset <= 1'b1;
         r_load_done  <= 1'b0;
         r_load_err   <= 1'b0;
         r_byte_count <= '0;
         r_checksum   <= '0;
      end else begin
         r_dl_sel_q   <= w_dl_sel;
         r_dn_wr      <= 1'b0;
         r_core_reset <= (w_state_nx != READY);

         if (w_clear) begin
            r_byte_count <= '0;
            r_checksum   <= '0;
            r_load_err   <= 1'b0;
            r_load_done  <= 1'b0;
         end

         if (w_accept) begin
            if (w_in_range) begin
               r_dn_addr  <= ioctl_addr[ADDR_W-1:0];
               r_dn_data  <= ioctl_dout;
               r_dn_wr    <= 1'b1;
               r_checksum <= r_checksum + ioctl_dout;
               if (r_byte_count != CNT_MAX) begin
                  r_byte_count <= r_byte_count + (ADDR_W + 1)'(1);
               end
               if (!w_seq_ok) begin
                  r_load_err <= 1'b1;
               end
            end else begin
               r_load_err <= 1'b1;
            end
         end

         if (w_hold_load) begin
            r_hold_cnt <= HOLD_INIT;
         end else if (w_hold_dec) begin
            r_hold_cnt <= r_hold_cnt - CNT_W'(1);
         end

         if (w_finish) begin
            r_load_done <= 1'b1;
            if ((EXPECTED_BYTES != 0) && (r_byte_count != EXP_CNT)) begin
               r_load_err <= 1'b1;
            end
         end
      end
   end

   assign dn_addr    = r_dn_addr;
   assign dn_data    = r_dn_data;
   assign dn_wr      = r_dn_wr;
   assign core_reset = r_core_reset;
   assign load_done  = r_load_done;
   assign load_err   = r_load_err;
   assign byte_count = r_byte_count;
   assign checksum   = r_checksum;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// tb/tb_rom_download_ctrl.sv - randomized self-checking bench for rom_download_ctrl
module tb_rom_download_ctrl;

   localparam int ADDR_W    = 18;
   localparam int EXP_BYTES = 4;
   localparam int POST_HOLD = 16;

   logic              clk_sys = 1'b0;
   logic              reset_n = 1'b0;
   logic              ioctl_download = 1'b0;
   logic              ioctl_wr = 1'b0;
   logic [24:0]       ioctl_addr = '0;
   logic [7:0]        ioctl_dout = '0;
   logic [15:0]       ioctl_index = '0;
   logic [ADDR_W-1:0] dn_addr;
   logic [7:0]        dn_data;
   logic              dn_wr;
   logic              core_reset;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   byte_count;
   logic [7:0]        checksum;

   rom_download_ctrl #(
      .ROM_INDEX      (16'd0),
      .ADDR_W         (ADDR_W),
      .EXPECTED_BYTES (EXP_BYTES),
      .POST_HOLD      (POST_HOLD)
   ) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_index    (ioctl_index),
      .dn_addr        (dn_addr),
      .dn_data        (dn_data),
      .dn_wr          (dn_wr),
      .core_reset     (core_reset),
      .load_done      (load_done),
      .load_err       (load_err),
      .byte_count     (byte_count),
      .checksum       (checksum)
   );

   always #5 clk_sys = ~clk_sys;

   int n_cmp = 0;
   int n_mis = 0;

   logic [24:0] s_addr[$];
   logic [7:0]  s_data[$];
   logic [31:0] obs_a[$];
   logic [7:0]  obs_d[$];

   int       m_count;
   logic [7:0] m_sum;
   bit       m_err;
   bit       m_done;
   bit       m_core_reset;

   always @(negedge clk_sys) begin
      if (dn_wr === 1'b1) begin
         obs_a.push_back(32'(dn_addr));
         obs_d.push_back(dn_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_dn_addr",    32'(dn_addr),    32'd0);
      check("rst_dn_data",    32'(dn_data),    32'd0);
      check("rst_dn_wr",      32'(dn_wr),      32'd0);
      check("rst_core_reset", 32'(core_reset), 32'd1);
      check("rst_load_done",  32'(load_done),  32'd0);
      check("rst_load_err",   32'(load_err),   32'd0);
      check("rst_byte_count", 32'(byte_count), 32'd0);
      check("rst_checksum",   32'(checksum),   32'd0);
   endtask

   task automatic model_reset();
      m_count = 0; m_sum = 8'h00; m_err = 1'b0; m_done = 1'b0; m_core_reset = 1'b1;
   endtask

   task automatic load_seq(input int n);
      s_addr.delete(); s_data.delete();
      for (int i = 0; i < n; i++) begin
         s_addr.push_back(25'(i));
         s_data.push_back(8'($urandom_range(0, 255)));
      end
   endtask

   // Runs one download from s_addr/s_data and checks the result against the spec rules.
   task automatic do_download(input logic [15:0] idx, input bit already_on, input bit drop_last);
      logic [31:0] exp_a[$];
      logic [7:0]  exp_d[$];
      int          cnt;
      logic [7:0]  sum;
      bit          err;
      int          n;
      int          gap;
      bit          last;

      cnt = 0; sum = 8'h00; err = 1'b0;
      for (int i = 0; i < s_addr.size(); i++) begin
         if (s_addr[i] >= 25'h40000) begin
            err = 1'b1;
         end else begin
            if (s_addr[i] != 25'(cnt)) err = 1'b1;
            exp_a.push_back(32'(s_addr[i]));
            exp_d.push_back(s_data[i]);
            cnt++;
            sum = sum + s_data[i];
         end
      end
      if (cnt != EXP_BYTES) err = 1'b1;

      obs_a.delete(); obs_d.delete();
      if (!already_on) begin
         @(posedge clk_sys); #1;
         ioctl_index    = idx;
         ioctl_download = 1'b1;
      end
      @(posedge clk_sys); #1;
      for (int i = 0; i < s_addr.size(); i++) begin
         last       = (i == s_addr.size() - 1);
         ioctl_wr   = 1'b1;
         ioctl_addr = s_addr[i];
         ioctl_dout = s_data[i];
         if (last && drop_last) ioctl_download = 1'b0;
         @(posedge clk_sys); #1;
         ioctl_wr = 1'b0;
         if (!(last && drop_last)) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk_sys); #1; end
         end
      end
      if (!drop_last) begin
         ioctl_download = 1'b0;
         @(posedge clk_sys);
      end

      if (idx == 16'd0) begin
         n = 0;
         for (int k = 0; k < 200; k++) begin
            @(negedge clk_sys);
            if (core_reset == 1'b0) break;
            n++;
         end
         check("hold_cycles", 32'(n), 32'(POST_HOLD));
         m_count = cnt; m_sum = sum; m_err = err; m_done = 1'b1; m_core_reset = 1'b0;
         check("wr_count", 32'(obs_a.size()), 32'(exp_a.size()));
         for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            check("wr_addr", obs_a[i], exp_a[i]);
            check("wr_data", 32'(obs_d[i]), 32'(exp_d[i]));
         end
      end else begin
         repeat (5) @(posedge clk_sys);
         #1;
         check("other_idx_wr", 32'(obs_a.size()), 32'd0);
      end
      check("byte_count", 32'(byte_count), 32'(m_count));
      check("checksum",   32'(checksum),   32'(m_sum));
      check("load_err",   32'(load_err),   32'(m_err));
      check("load_done",  32'(load_done),  32'(m_done));
      check("core_reset", 32'(core_reset), 32'(m_core_reset));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          ninr;
      int          len;
      int          r;
      logic [24:0] a;

      model_reset();
      repeat (3) @(posedge clk_sys);
      #1;
      check_reset_vals();
      @(negedge clk_sys);
      reset_n = 1'b1;

      repeat (50) @(posedge clk_sys);
      #1;
      check("idle_core_reset", 32'(core_reset), 32'd1);
      check("idle_load_done",  32'(load_done),  32'd0);
      check("idle_no_wr",      32'(obs_a.size()), 32'd0);

      load_seq(16);
      do_download(16'd1, 1'b0, 1'b0);

      s_addr = '{25'd0, 25'd1, 25'd2, 25'd3};
      s_data = '{8'h01, 8'h02, 8'h03, 8'hFF};
      do_download(16'd0, 1'b0, 1'b0);
      check("dir_checksum", 32'(checksum),   32'h05);
      check("dir_count",    32'(byte_count), 32'd4);
      check("dir_err",      32'(load_err),   32'd0);

      load_seq(16);
      do_download(16'd1, 1'b0, 1'b0);

      s_addr = '{25'd0, 25'h40000, 25'd1, 25'd2, 25'd3};
      s_data = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      do_download(16'd0, 1'b0, 1'b0);

      s_addr = '{25'd0, 25'd1, 25'd3};
      s_data = '{8'hA1, 8'hA2, 8'hA3};
      do_download(16'd0, 1'b0, 1'b0);

      load_seq(3);
      do_download(16'd0, 1'b0, 1'b1);

      @(posedge clk_sys); #1;
      ioctl_index    = 16'd0;
      ioctl_download = 1'b1;
      @(posedge clk_sys); #1;
      check("reassert_core_reset", 32'(core_reset), 32'd1);
      check("reassert_load_done",  32'(load_done),  32'd0);
      check("reassert_byte_count", 32'(byte_count), 32'd0);
      load_seq(4);
      do_download(16'd0, 1'b1, 1'b0);

      @(posedge clk_sys); #1;
      ioctl_index    = 16'd0;
      ioctl_download = 1'b1;
      @(posedge clk_sys); #1;
      for (int i = 0; i < 2; i++) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'h5A;
         @(posedge clk_sys); #1;
         ioctl_wr = 1'b0;
      end
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_vals();
      @(negedge clk_sys);
      reset_n = 1'b1;
      model_reset();
      load_seq(4);
      do_download(16'd0, 1'b1, 1'b0);

      for (int t = 0; t < 20; t++) begin
         len = $urandom_range(1, 8);
         ninr = 0;
         s_addr.delete(); s_data.delete();
         for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
               a = {7'($urandom_range(1, 127)), 18'($urandom_range(0, 262143))};
            end else if (r == 1) begin
               a = 25'($urandom_range(0, 262143));
               ninr++;
            end else begin
               a = 25'(ninr);
               ninr++;
            end
            s_addr.push_back(a);
            s_data.push_back(8'($urandom_range(0, 255)));
         end
         if ($urandom_range(0, 3) == 0) begin
            do_download(16'd1, 1'b0, 1'(($urandom_range(0, 1))));
         end else begin
            do_download(16'd0, 1'b0, 1'(($urandom_range(0, 1))));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
